// File: rtl/me_pkg.sv
// me_pkg: shared widths, frame geometry defaults and the result entry type
package me_pkg;
    localparam int BLK_W_DEF = 240;
    localparam int BLK_H_DEF = 135;
    localparam int SAD_W = 14;
    localparam int MV_W = 4;
    localparam int BLK_IDX_W = 8;
    typedef struct packed {
        logic [SAD_W-1:0]     sad;
        logic [MV_W-1:0]      mv_x;
        logic [MV_W-1:0]      mv_y;
        logic [BLK_IDX_W-1:0] blk_x;
        logic [BLK_IDX_W-1:0] blk_y;
        logic                 last;
    } mv_entry_t;
endpackage

// File: rtl/mv_fifo.sv
// mv_fifo: small synchronous FIFO that drops pushes arriving while full with no pop
module mv_fifo
    import me_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = mv_entry_t,
    localparam int PW = $clog2(DEPTH),
    localparam int LW = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  entry_t        din_i,
    output entry_t        dout_o,
    output logic          empty_o,
    output logic          drop_o,
    output logic [LW-1:0] level_o
);
    logic [PW-1:0] wr_q, rd_q;
    logic [LW-1:0] level_q, level_d;
    logic          full, pop_ok, push_ok;
    entry_t        mem_q [DEPTH];
    // a pop frees a slot in the same cycle, so a full FIFO can still take a push alongside it
    always_comb begin
        full    = level_q == LW'(DEPTH);
        pop_ok  = pop_i && level_q != '0;
        push_ok = push_i && (!full || pop_ok);
        drop_o  = push_i && !push_ok;
        level_d = level_q + LW'(push_ok) - LW'(pop_ok);
    end
    // storage and pointers; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop_ok) rd_q <= rd_q + PW'(1);
            level_q <= level_d;
        end
    end
    assign dout_o  = mem_q[rd_q];
    assign empty_o = level_q == '0;
    assign level_o = level_q;
endmodule

// File: rtl/mv_result_collector.sv
// mv_result_collector: tags SAD core results with raster block position and queues them for write-back
module mv_result_collector
    import me_pkg::*;
#(
    parameter int BLK_W = BLK_W_DEF,
    parameter int BLK_H = BLK_H_DEF,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sad_en,
    input  logic [SAD_W-1:0]         sad_min,
    input  logic [MV_W-1:0]          motion_vec_x_min,
    input  logic [MV_W-1:0]          motion_vec_y_min,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SAD_W-1:0]         out_sad,
    output logic [MV_W-1:0]          out_mv_x,
    output logic [MV_W-1:0]          out_mv_y,
    output logic [BLK_IDX_W-1:0]     out_blk_x,
    output logic [BLK_IDX_W-1:0]     out_blk_y,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [$clog2(DEPTH):0]   level
);
    logic                 sad_en_q, skip_q, frame_done_q, overflow_q;
    logic [BLK_IDX_W-1:0] blk_x_q, blk_x_d, blk_y_q, blk_y_d;
    logic                 push, at_row_end, at_last, drop, empty;
    mv_entry_t            entry, head;
    // the core's result is final one edge after its strobe, so capture on the delayed strobe
    always_comb begin
        push       = sad_en_q && !skip_q;
        at_row_end = blk_x_q == BLK_IDX_W'(BLK_W - 1);
        at_last    = at_row_end && blk_y_q == BLK_IDX_W'(BLK_H - 1);
        blk_x_d    = !push ? blk_x_q : at_row_end ? '0 : blk_x_q + BLK_IDX_W'(1);
        blk_y_d    = !(push && at_row_end) ? blk_y_q : at_last ? '0 : blk_y_q + BLK_IDX_W'(1);
        entry      = '{sad: sad_min, mv_x: motion_vec_x_min, mv_y: motion_vec_y_min,
                       blk_x: blk_x_q, blk_y: blk_y_q, last: at_last};
    end
    // strobe delay, first-strobe discard, raster counters (advance even on drops), status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sad_en_q     <= 1'b0;
            skip_q       <= 1'b1;
            blk_x_q      <= '0;
            blk_y_q      <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sad_en_q     <= sad_en;
            if (sad_en_q) skip_q <= 1'b0;
            blk_x_q      <= blk_x_d;
            blk_y_q      <= blk_y_d;
            frame_done_q <= push && at_last;
            overflow_q   <= drop || (overflow_q && !clr_overflow);
        end
    end
    mv_fifo #(.DEPTH(DEPTH), .entry_t(mv_entry_t)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (out_ready),
        .din_i   (entry),
        .dout_o  (head),
        .empty_o (empty),
        .drop_o  (drop),
        .level_o (level)
    );
    assign out_valid  = !empty;
    assign out_sad    = head.sad;
    assign out_mv_x   = head.mv_x;
    assign out_mv_y   = head.mv_y;
    assign out_blk_x  = head.blk_x;
    assign out_blk_y  = head.blk_y;
    assign out_last   = head.last;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
endmodule

// File: doc/mv_result_collector.md
Name: mv_result_collector

Overview:
- Sits directly downstream of the 16-column SAD/compare core.
- Captures each per-block result {sad_min, motion_vec_x_min, motion_vec_y_min} when the core signals completion.
- Tags each result with its raster block position in the 3840x2160 frame (16x16 blocks) and buffers it in a small FIFO.
- Presents results to the write-back stage over a valid/ready handshake and flags end of frame and overflow.

Parameters:
- BLK_W, 240, blocks per row (3840/16)
- BLK_H, 135, block rows per frame (2160/16)
- DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sad_en  in  1  core completion strobe, one cycle every 25
- sad_min  in  14  core minimum SAD
- motion_vec_x_min  in  4  core best x offset
- motion_vec_y_min  in  4  core best y offset
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts head this cycle
- out_sad  out  14  head SAD
- out_mv_x  out  4  head x vector
- out_mv_y  out  4  head y vector
- out_blk_x  out  8  head block column, 0..BLK_W-1
- out_blk_y  out  8  head block row, 0..BLK_H-1
- out_last  out  1  head is last block of frame
- frame_done  out  1  one-cycle pulse when the last block of a frame is captured
- overflow  out  1  sticky: a capture was dropped because the FIFO was full
- clr_overflow  in  1  synchronous clear of overflow
- level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n low): all outputs 0; FIFO empty; blk_x/blk_y = 0; skip_first = 1; sad_en_d = 0.
- Capture timing:
  - sad_en is registered to sad_en_d. The core's result registers complete their final update on the edge where sad_en is high.
  - Capture therefore happens on the edge where sad_en_d = 1, sampling sad_min, motion_vec_x_min and motion_vec_y_min at that edge.
- First-strobe discard:
  - The first sad_en_d after reset is discarded (the core asserts sad_en at count 0 with no valid result).
  - A discard clears skip_first; counters and FIFO are untouched.
- Block position:
  - Each non-discarded capture uses the current (blk_x, blk_y), then advances.
  - blk_x increments; at BLK_W-1 it wraps to 0 and blk_y increments.
  - When blk_y = BLK_H-1 and blk_x = BLK_W-1, both wrap to 0, out_last is stored 1 for that entry, and frame_done pulses on the same edge the entry is written (or dropped).
- Counters advance on every capture, including dropped ones, so positions never slip.
- FIFO push/pop:
  - push = capture; pop = out_valid & out_ready.
  - Push is accepted if level < DEPTH or pop happens in the same cycle (full + simultaneous pop: both occur, level unchanged).
  - Push while full with no pop: entry dropped, overflow set to 1, level stays DEPTH.
  - Pop on empty is ignored.
- Output timing:
  - out_valid = (level != 0). Head data comes combinationally from the storage array at the read pointer.
  - No bypass: an entry pushed into an empty FIFO is visible on out_* the cycle after the push edge.
  - Head data is stable while out_valid & !out_ready.
- Overflow control: clr_overflow clears overflow. If clr_overflow coincides with a new drop, overflow stays 1.
- Pointers: wrap modulo DEPTH; level is updated by +1 / -1 / 0.
- Throughput: captures arrive at most every 25 cycles, so a consumer stalling fewer than 25*DEPTH cycles never overflows.
- Reset mid-frame: everything returns to the reset state; the next frame starts at block (0,0) after one discarded strobe.

Decomposition:
- Shared package me_pkg holds:
  - BLK_W/BLK_H defaults
  - SAD_W=14, MV_W=4, BLK_IDX_W=8
  - an mv_entry_t struct {sad, mv_x, mv_y, blk_x, blk_y, last} (39 bits).
- Sub-module mv_fifo: a synchronous FIFO parameterised by DEPTH and entry type.
  - Provides push/pop/full/empty/level and the drop-on-full rule.
- The top contains the strobe delay, the skip_first flag, the raster counters, frame_done and overflow.

Test Plan:
- Reset release, then the core runs with sad_en every 25 cycles. Expected:
  - the first strobe is discarded, level stays 0;
  - the second strobe (sad_min=100, x=3, y=5) yields out_valid one cycle after capture with out_sad=100, out_mv_x=3, out_mv_y=5, blk (0,0).
- out_ready held 1 for 241 results. Expected: the 240th entry has blk (239,0), the 241st has blk (0,1), and out_last stays 0.
- Reduced params BLK_W=4, BLK_H=2, 8 results. Expected: the 8th has blk (3,1) and out_last=1; frame_done pulses once on its capture edge; the 9th is at (0,0).
- out_ready=0 for 6 captures, DEPTH=4. Expected: level=4, two drops, overflow=1; after reads the entries are the first four in order, and blk indices skip the dropped two.
- FIFO full and a capture coincide with out_ready=1. Expected: level stays 4, no overflow, the new entry lands at the tail. Then clr_overflow pulse: overflow=0.
- Assert rst_n low mid-frame with 2 entries queued. Expected: out_valid=0 immediately (async); after release the first strobe is discarded and the next result is tagged (0,0).
